// File: rtl/rv32_pipe_pkg.sv
// Shared RV32IM pipeline definitions: datapath widths, control-bundle bit
// map and ALU opcode encodings used by the decode, ID/EX and ALU blocks.
package rv32_pipe_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int CTRL_W   = 8;
    localparam int ALU_OP_W = 5;
    localparam int FUNCT3_W = 3;

    // Control bundle bit positions
    localparam int REG_WRITE   = 0;
    localparam int MEM_READ    = 1;
    localparam int MEM_WRITE   = 2;
    localparam int BRANCH      = 3;
    localparam int JUMP        = 4;
    localparam int ALU_SRC_IMM = 5;
    localparam int USE_RS1     = 6;
    localparam int USE_RS2     = 7;

    // ALU / MUL / DIV opcodes
    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'd9;
    localparam logic [ALU_OP_W-1:0] ALU_LUI    = 5'd10;
    localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'd16;
    localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'd17;
    localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'd18;
    localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'd19;
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'd20;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'd21;
    localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'd22;
    localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'd23;

endpackage

// File: rtl/hazard_unit_lu.sv
// Load-use hazard detector: flags when the instruction in decode reads the
// destination of a load currently sitting in ID/EX. Purely combinational.
module hazard_unit_lu
    import rv32_pipe_pkg::*;
(
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              id_valid,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              stall,
    output logic              load_use_stall
);

    logic rs1_hit;
    logic rs2_hit;

    // Compare decode sources against the in-flight load destination; an
    // external stall already freezes everything, so no bubble is requested then.
    always_comb begin
        rs1_hit        = id_use_rs1 && (id_rs1_addr == ex_rd_addr);
        rs2_hit        = id_use_rs2 && (id_rs2_addr == ex_rd_addr);
        load_use_stall = ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
                         id_valid && (rs1_hit || rs2_hit) && !stall;
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// stall hold (with operand refresh) and flush.
// Optional perf counters (BUBBLE_COUNT / FLUSH_COUNT) under ID_EX_PERF_CNT_EN.
//
// Valid semantics: OUT_VALID marks a real instruction in EX. There is no
// ready back-pressure; STALL holds the stage, LOAD_USE_STALL tells the
// upstream stages to hold so the same decode instruction is re-presented.
module id_ex_stage_reg
    import rv32_pipe_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                STALL,
    input  logic                FLUSH,
    input  logic                IN_VALID,
    input  logic [XLEN-1:0]     IN_PC,
    input  logic [REG_AW-1:0]   IN_RS1_ADDR,
    input  logic [REG_AW-1:0]   IN_RS2_ADDR,
    input  logic [REG_AW-1:0]   IN_RD_ADDR,
    input  logic [XLEN-1:0]     IN_DATA1,
    input  logic [XLEN-1:0]     IN_DATA2,
    input  logic [XLEN-1:0]     IN_IMM,
    input  logic [ALU_OP_W-1:0] IN_ALU_OP,
    input  logic [FUNCT3_W-1:0] IN_FUNCT3,
    input  logic [CTRL_W-1:0]   IN_CTRL,
    input  logic                WB_WRITE_ENABLE,
    input  logic [REG_AW-1:0]   WB_WRITE_ADDRESS,
    input  logic [XLEN-1:0]     WB_WRITE_DATA,
    output logic                OUT_VALID,
    output logic [XLEN-1:0]     OUT_PC,
    output logic [XLEN-1:0]     OUT_IMM,
    output logic [XLEN-1:0]     OUT_DATA1,
    output logic [XLEN-1:0]     OUT_DATA2,
    output logic [REG_AW-1:0]   OUT_RS1_ADDR,
    output logic [REG_AW-1:0]   OUT_RS2_ADDR,
    output logic [REG_AW-1:0]   OUT_RD_ADDR,
    output logic [ALU_OP_W-1:0] OUT_ALU_OP,
    output logic [FUNCT3_W-1:0] OUT_FUNCT3,
    output logic [CTRL_W-1:0]   OUT_CTRL,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]         BUBBLE_COUNT,
    output logic [31:0]         FLUSH_COUNT,
`endif
    output logic                LOAD_USE_STALL
);

    logic                valid_q,  valid_d;
    logic [XLEN-1:0]     pc_q,     pc_d;
    logic [XLEN-1:0]     imm_q,    imm_d;
    logic [XLEN-1:0]     data1_q,  data1_d;
    logic [XLEN-1:0]     data2_q,  data2_d;
    logic [REG_AW-1:0]   rs1_q,    rs1_d;
    logic [REG_AW-1:0]   rs2_q,    rs2_d;
    logic [REG_AW-1:0]   rd_q,     rd_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic [FUNCT3_W-1:0] funct3_q, funct3_d;
    logic [CTRL_W-1:0]   ctrl_q,   ctrl_d;

    logic            wb_live;
    logic [XLEN-1:0] byp_data1;
    logic [XLEN-1:0] byp_data2;
    logic            lu_stall;

    hazard_unit_lu u_hazard (
        .ex_valid       (valid_q),
        .ex_mem_read    (ctrl_q[MEM_READ]),
        .ex_rd_addr     (rd_q),
        .id_valid       (IN_VALID),
        .id_use_rs1     (IN_CTRL[USE_RS1]),
        .id_use_rs2     (IN_CTRL[USE_RS2]),
        .id_rs1_addr    (IN_RS1_ADDR),
        .id_rs2_addr    (IN_RS2_ADDR),
        .stall          (STALL),
        .load_use_stall (lu_stall)
    );

    // Writeback bypass around the register file; x0 is never forwarded.
    always_comb begin
        wb_live   = WB_WRITE_ENABLE && (WB_WRITE_ADDRESS != '0);
        byp_data1 = (wb_live && WB_WRITE_ADDRESS == IN_RS1_ADDR) ? WB_WRITE_DATA : IN_DATA1;
        byp_data2 = (wb_live && WB_WRITE_ADDRESS == IN_RS2_ADDR) ? WB_WRITE_DATA : IN_DATA2;
    end

    // Next-state selection: flush > stall (hold + refresh) > load-use bubble > capture.
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        alu_op_d = alu_op_q;
        funct3_d = funct3_q;
        ctrl_d   = ctrl_q;
        if (FLUSH || (!STALL && lu_stall)) begin
            valid_d  = 1'b0;
            pc_d     = '0;
            imm_d    = '0;
            data1_d  = '0;
            data2_d  = '0;
            rs1_d    = '0;
            rs2_d    = '0;
            rd_d     = '0;
            alu_op_d = '0;
            funct3_d = '0;
            ctrl_d   = '0;
        end else if (STALL) begin
            // Keep held operands current while EX is busy for many cycles.
            if (valid_q && wb_live && WB_WRITE_ADDRESS == rs1_q) data1_d = WB_WRITE_DATA;
            if (valid_q && wb_live && WB_WRITE_ADDRESS == rs2_q) data2_d = WB_WRITE_DATA;
        end else begin
            valid_d  = IN_VALID;
            pc_d     = IN_PC;
            imm_d    = IN_IMM;
            data1_d  = byp_data1;
            data2_d  = byp_data2;
            rs1_d    = IN_RS1_ADDR;
            rs2_d    = IN_RS2_ADDR;
            rd_d     = IN_RD_ADDR;
            alu_op_d = IN_ALU_OP;
            funct3_d = IN_FUNCT3;
            ctrl_d   = IN_VALID ? IN_CTRL : '0;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            imm_q    <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            alu_op_q <= '0;
            funct3_q <= '0;
            ctrl_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            alu_op_q <= alu_op_d;
            funct3_q <= funct3_d;
            ctrl_q   <= ctrl_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q,  flush_cnt_d;

    // Counters wrap naturally at 32 bits.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!FLUSH && !STALL && lu_stall) bubble_cnt_d = bubble_cnt_q + 32'd1;
        if (FLUSH) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign BUBBLE_COUNT = bubble_cnt_q;
    assign FLUSH_COUNT  = flush_cnt_q;
`endif

    assign OUT_VALID      = valid_q;
    assign OUT_PC         = pc_q;
    assign OUT_IMM        = imm_q;
    assign OUT_DATA1      = data1_q;
    assign OUT_DATA2      = data2_q;
    assign OUT_RS1_ADDR   = rs1_q;
    assign OUT_RS2_ADDR   = rs2_q;
    assign OUT_RD_ADDR    = rd_q;
    assign OUT_ALU_OP     = alu_op_q;
    assign OUT_FUNCT3     = funct3_q;
    assign OUT_CTRL       = ctrl_q;
    assign LOAD_USE_STALL = lu_stall;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg. Inputs change on the falling edge,
// outputs are checked on the falling edge (half a cycle from the active edge).
module tb_id_ex_stage_reg;
    import rv32_pipe_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                stall, flush, in_valid;
    logic [XLEN-1:0]     in_pc, in_data1, in_data2, in_imm;
    logic [REG_AW-1:0]   in_rs1, in_rs2, in_rd;
    logic [ALU_OP_W-1:0] in_alu_op;
    logic [FUNCT3_W-1:0] in_funct3;
    logic [CTRL_W-1:0]   in_ctrl;
    logic                wb_we;
    logic [REG_AW-1:0]   wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                out_valid;
    logic [XLEN-1:0]     out_pc, out_imm, out_data1, out_data2;
    logic [REG_AW-1:0]   out_rs1, out_rs2, out_rd;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic [FUNCT3_W-1:0] out_funct3;
    logic [CTRL_W-1:0]   out_ctrl;
    logic                lus;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]         bubble_count, flush_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .CLK(clk), .RESET_N(rst_n), .STALL(stall), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_PC(in_pc),
        .IN_RS1_ADDR(in_rs1), .IN_RS2_ADDR(in_rs2), .IN_RD_ADDR(in_rd),
        .IN_DATA1(in_data1), .IN_DATA2(in_data2), .IN_IMM(in_imm),
        .IN_ALU_OP(in_alu_op), .IN_FUNCT3(in_funct3), .IN_CTRL(in_ctrl),
        .WB_WRITE_ENABLE(wb_we), .WB_WRITE_ADDRESS(wb_addr), .WB_WRITE_DATA(wb_data),
        .OUT_VALID(out_valid), .OUT_PC(out_pc), .OUT_IMM(out_imm),
        .OUT_DATA1(out_data1), .OUT_DATA2(out_data2),
        .OUT_RS1_ADDR(out_rs1), .OUT_RS2_ADDR(out_rs2), .OUT_RD_ADDR(out_rd),
        .OUT_ALU_OP(out_alu_op), .OUT_FUNCT3(out_funct3), .OUT_CTRL(out_ctrl),
`ifdef ID_EX_PERF_CNT_EN
        .BUBBLE_COUNT(bubble_count), .FLUSH_COUNT(flush_count),
`endif
        .LOAD_USE_STALL(lus)
    );

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic v, input logic [31:0] pc,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [4:0] op, input logic [2:0] f3, input logic [7:0] ctrl);
        in_valid  = v;   in_pc    = pc;
        in_rs1    = rs1; in_rs2   = rs2; in_rd = rd;
        in_data1  = d1;  in_data2 = d2;  in_imm = imm;
        in_alu_op = op;  in_funct3 = f3; in_ctrl = ctrl;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        wb_we = we; wb_addr = addr; wb_data = data;
    endtask

    // Control bundles used below
    localparam logic [7:0] C_LW   = 8'h43; // REG_WRITE | MEM_READ | USE_RS1
    localparam logic [7:0] C_ADD  = 8'hC1; // REG_WRITE | USE_RS1 | USE_RS2
    localparam logic [7:0] C_LW2  = 8'h83; // REG_WRITE | MEM_READ | USE_RS2
    localparam logic [7:0] C_ADDI = 8'h61; // REG_WRITE | ALU_SRC_IMM | USE_RS1

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_instr(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h4, ALU_ADD, 3'd0, C_ADD);
        set_wb(1'b0, 5'd0, 32'h0);

        // Reset held with live inputs and running clock
        repeat (3) step();
        check("rst_valid", out_valid, 0);
        check("rst_pc",    out_pc,    0);
        check("rst_ctrl",  out_ctrl,  0);
        check("rst_data1", out_data1, 0);
        check("rst_lus",   lus,       0);
`ifdef ID_EX_PERF_CNT_EN
        check("rst_bcnt", bubble_count, 0);
        check("rst_fcnt", flush_count,  0);
`endif
        rst_n = 1'b1;
        step();
        check("cap_pc",    out_pc,    32'h100);
        check("cap_valid", out_valid, 1);
        check("cap_ctrl",  out_ctrl,  C_ADD);
        check("cap_rd",    out_rd,    3);
        check("cap_imm",   out_imm,   4);

        // WB bypass into operand 1, operand 2 unaffected
        set_instr(1'b1, 32'h104, 5'd5, 5'd6, 5'd4, 32'h11, 32'h22, 32'h8, ALU_SUB, 3'd0, C_ADD);
        set_wb(1'b1, 5'd5, 32'hABCD);
        step();
        check("byp_data1", out_data1, 32'hABCD);
        check("byp_data2", out_data2, 32'h22);
        check("byp_op",    out_alu_op, ALU_SUB);

        // x0 is never bypassed
        set_instr(1'b1, 32'h108, 5'd0, 5'd6, 5'd4, 32'h11, 32'h22, 32'h8, ALU_ADD, 3'd0, C_ADD);
        set_wb(1'b1, 5'd0, 32'hABCD);
        step();
        check("x0_data1", out_data1, 32'h11);

        // Invalid decode slot: valid and control cleared
        set_wb(1'b0, 5'd0, 32'h0);
        set_instr(1'b0, 32'h10C, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_ADD, 3'd0, 8'hFF);
        step();
        check("inv_valid", out_valid, 0);
        check("inv_ctrl",  out_ctrl,  0);

        // Load-use: lw x7 then add using x7 as rs2
        set_instr(1'b1, 32'h110, 5'd1, 5'd0, 5'd7, 32'h1000, 32'h0, 32'h0, ALU_ADD, 3'd2, C_LW);
        step();
        check("lw_lus_idle", lus, 0);
        set_instr(1'b1, 32'h114, 5'd2, 5'd7, 5'd8, 32'h5, 32'h6, 32'h0, ALU_ADD, 3'd0, C_ADD);
        #1;
        check("lu_lus", lus, 1);
        step();
        check("lu_bub_valid", out_valid, 0);
        check("lu_bub_ctrl",  out_ctrl,  0);
        check("lu_lus_clear", lus, 0);
        step();
        check("lu_rep_valid", out_valid, 1);
        check("lu_rep_pc",    out_pc,    32'h114);
        check("lu_rep_ctrl",  out_ctrl,  C_ADD);
`ifdef ID_EX_PERF_CNT_EN
        check("lu_bcnt", bubble_count, 1);
`endif

        // Stall refresh: load with rs2=9 held four cycles, WB x9 in cycle 2
        set_instr(1'b1, 32'h200, 5'd3, 5'd9, 5'd10, 32'h33, 32'h99, 32'h44, ALU_ADD, 3'd2, C_LW2);
        step();
        check("st_cap_d2", out_data2, 32'h99);
        // Hazardous decode instruction (reads x10) must not raise LUS under stall
        set_instr(1'b1, 32'h204, 5'd10, 5'd1, 5'd11, 32'h7, 32'h8, 32'h0, ALU_ADD, 3'd0, C_ADDI);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) set_wb(1'b1, 5'd9, 32'h55);
            else        set_wb(1'b0, 5'd9, 32'hDEAD);
            #1;
            check("st_lus", lus, 0);
            step();
        end
        set_wb(1'b0, 5'd0, 32'h0);
        check("st_data2", out_data2, 32'h55);
        check("st_data1", out_data1, 32'h33);
        check("st_pc",    out_pc,    32'h200);
        check("st_imm",   out_imm,   32'h44);
        check("st_rd",    out_rd,    10);
        check("st_ctrl",  out_ctrl,  C_LW2);
        check("st_valid", out_valid, 1);
        stall = 1'b0;
        #1;
        check("st_rel_lus", lus, 1);

        // FLUSH together with STALL
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ctrl",  out_ctrl,  0);
        check("fl_pc",    out_pc,    0);
`ifdef ID_EX_PERF_CNT_EN
        check("fl_fcnt", flush_count,  1);
        check("fl_bcnt", bubble_count, 1);

        // Counter wrap: preload bubble counter then cause one bubble
        set_instr(1'b1, 32'h300, 5'd1, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, ALU_ADD, 3'd2, C_LW);
        step();
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        set_instr(1'b1, 32'h304, 5'd2, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, ALU_ADD, 3'd0, C_ADD);
        step();
        check("wrap_bcnt", bubble_count, 0);
`endif

        // Asynchronous reset mid-stall takes effect without a clock edge
        set_instr(1'b1, 32'h400, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, ALU_ADD, 3'd0, C_ADD);
        step();
        check("pre_ar_valid", out_valid, 1);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_pc",    out_pc,    0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
